hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 148 ++++++++++++++
 tb/tb_hazard_scoreboard.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Load-use hazard detection for a pipeline whose loads become forwardable
//   LOAD_LAT cycles after entering EX. The loads still in flight past EX are
//   tracked in a short shift register of {valid, rd}. HDUStall holds PC and
//   IF/ID and inserts a bubble into ID/EX.
//
//   Optional feature: define HDU_STALL_CNT_EN to add the saturating StallCnt
//   output and its register. Without the macro the port does not exist and
//   the stall behaviour is unchanged.
//
//   Handshake: there is no valid/ready pair. HDUStall is a level that is
//   valid combinationally in the same cycle as its inputs. The upstream
//   stages must honour it in that cycle, and nothing acknowledges it.
module hazard_scoreboard #(
   parameter int REG_W    = 5,
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             DMRd_ex,
   input  logic [REG_W-1:0] rd_ex,
   input  logic [REG_W-1:0] rs1_de,
   input  logic [REG_W-1:0] rs2_de,
   input  logic             rs1_used_de,
   input  logic             rs2_used_de,
   input  logic             BrTaken_ex,
   output logic             HDUStall
`ifdef HDU_STALL_CNT_EN
   ,
   output logic [CNT_W-1:0] StallCnt
`endif
);

   // A load with LOAD_LAT=1 is forwardable right after EX, so nothing needs
   // to be remembered past EX. NPEND is kept at least 1 so that declarations
   // stay legal. The pending logic itself exists only when LOAD_LAT > 1.
   localparam int NPEND = (LOAD_LAT > 1) ? (LOAD_LAT - 1) : 1;

   logic ex_load_vld;
   logic rs1_pend_hit;
   logic rs2_pend_hit;
   logic rs1_haz;
   logic rs2_haz;

   // Only a load that writes a real register can create a hazard.
   always_comb begin
      ex_load_vld = DMRd_ex && (rd_ex != '0);
   end

   generate
      if (LOAD_LAT > 1) begin : g_pend
         logic [NPEND-1:0]            pend_vld_q;
         logic [NPEND-1:0]            pend_vld_d;
         logic [NPEND-1:0][REG_W-1:0] pend_rd_q;
         logic [NPEND-1:0][REG_W-1:0] pend_rd_d;

         // The shift register advances every cycle, even while stalled,
         // because EX always moves forward and only decode is held.
         always_comb begin
            pend_vld_d    = pend_vld_q;
            pend_rd_d     = pend_rd_q;
            pend_vld_d[0] = ex_load_vld;
            pend_rd_d[0]  = ex_load_vld ? rd_ex : '0;
            for (int k = 1; k < NPEND; k++) begin
               pend_vld_d[k] = pend_vld_q[k-1];
               pend_rd_d[k]  = pend_rd_q[k-1];
            end
         end

         // The pending register. Reset drops every load still in flight.
         always_ff @(posedge clk) begin
            if (rst) begin
               pend_vld_q <= '0;
               pend_rd_q  <= '0;
            end else begin
               pend_vld_q <= pend_vld_d;
               pend_rd_q  <= pend_rd_d;
            end
         end

         // A source is hit when any valid in-flight load targets it. When
         // several entries match, the result is still a single hit.
         always_comb begin
            rs1_pend_hit = 1'b0;
            rs2_pend_hit = 1'b0;
            for (int k = 0; k < NPEND; k++) begin
               if (pend_vld_q[k] && (pend_rd_q[k] == rs1_de)) begin
                  rs1_pend_hit = 1'b1;
               end
               if (pend_vld_q[k] && (pend_rd_q[k] == rs2_de)) begin
                  rs2_pend_hit = 1'b1;
               end
            end
         end
      end else begin : g_no_pend
         // With single-cycle load latency, only the load in EX matters.
         // clk clocks nothing here unless the stall counter is built.
         logic unused_clk;
         assign unused_clk   = clk;
         assign rs1_pend_hit = 1'b0;
         assign rs2_pend_hit = 1'b0;
      end
   endgenerate

   // A source is hazardous only when the decode instruction actually reads
   // it, it is not x0, and its producer is a load that is not yet
   // forwardable.
   always_comb begin
      rs1_haz = rs1_used_de && (rs1_de != '0) &&
                ((ex_load_vld && (rs1_de == rd_ex)) || rs1_pend_hit);
      rs2_haz = rs2_used_de && (rs2_de != '0) &&
                ((ex_load_vld && (rs2_de == rd_ex)) || rs2_pend_hit);
   end

   // A taken branch flushes decode, so a stall would only hold an
   // instruction that is about to be discarded. Reset suppresses the stall
   // outright.
   always_comb begin
      HDUStall = (rs1_haz || rs2_haz) && !BrTaken_ex && !rst;
   end

`ifdef HDU_STALL_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] stall_cnt_d;

   // Count stall cycles. The counter saturates at all ones instead of
   // wrapping, so a long run never reads as a short one.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (HDUStall && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   // The stall counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign StallCnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
//   Drives four instances (LOAD_LAT = 1..4) and one CNT_W=3 instance from
//   shared inputs. Expected stalls come from a list of issued loads and
//   their ages. HDU_STALL_CNT_EN selects whether the counters are checked.
module tb_hazard_scoreboard;

   localparam int REG_W = 5;
   localparam int CW    = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             DMRd_ex;
   logic [REG_W-1:0] rd_ex;
   logic [REG_W-1:0] rs1_de;
   logic [REG_W-1:0] rs2_de;
   logic             rs1_used_de;
   logic             rs2_used_de;
   logic             BrTaken_ex;
   logic [3:0]       stall_v;
   logic             stall_c;
`ifdef HDU_STALL_CNT_EN
   logic [31:0]      cnt_l [4];
   logic [CW-1:0]    cnt_c;
`endif

   int checks = 0;
   int errors = 0;

   // Clock and watchdog
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   for (genvar i = 0; i < 4; i++) begin : g_lat
      hazard_scoreboard #(.REG_W(REG_W), .LOAD_LAT(i + 1)) u_dut (
         .clk        (clk),
         .rst        (rst),
         .DMRd_ex    (DMRd_ex),
         .rd_ex      (rd_ex),
         .rs1_de     (rs1_de),
         .rs2_de     (rs2_de),
         .rs1_used_de(rs1_used_de),
         .rs2_used_de(rs2_used_de),
         .BrTaken_ex (BrTaken_ex),
         .HDUStall   (stall_v[i])
`ifdef HDU_STALL_CNT_EN
         ,
         .StallCnt   (cnt_l[i])
`endif
      );
   end

   hazard_scoreboard #(.REG_W(REG_W), .LOAD_LAT(2), .CNT_W(CW)) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .DMRd_ex    (DMRd_ex),
      .rd_ex      (rd_ex),
      .rs1_de     (rs1_de),
      .rs2_de     (rs2_de),
      .rs1_used_de(rs1_used_de),
      .rs2_used_de(rs2_used_de),
      .BrTaken_ex (BrTaken_ex),
      .HDUStall   (stall_c)
`ifdef HDU_STALL_CNT_EN
      ,
      .StallCnt   (cnt_c)
`endif
   );

   // Reference model: the loads issued since the last reset, each with the
   // cycle in which it was in EX.
   typedef struct {
      int               c;
      logic [REG_W-1:0] rd;
   } ld_t;

   ld_t         loads[$];
   int          cyc = 0;
   logic [31:0] cnt32 [4];
   int          cnt_sat = 0;
   logic [3:0]  exp_q[$];

   function automatic logic exp_src(int lat, logic [REG_W-1:0] rs, logic used);
      if (!used || rs == 0) return 1'b0;
      if (DMRd_ex && rd_ex == rs) return 1'b1;
      foreach (loads[i]) begin
         if ((cyc - loads[i].c) >= 1 && (cyc - loads[i].c) <= lat - 1 && loads[i].rd == rs)
            return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic logic exp_stall(int lat);
      return !rst && !BrTaken_ex &&
             (exp_src(lat, rs1_de, rs1_used_de) || exp_src(lat, rs2_de, rs2_used_de));
   endfunction

   // Driver tasks
   task automatic drive(input logic r, input logic ld, input logic [REG_W-1:0] rd,
                        input logic [REG_W-1:0] s1, input logic u1,
                        input logic [REG_W-1:0] s2, input logic u2, input logic br);
      rst         = r;
      DMRd_ex     = ld;
      rd_ex       = rd;
      rs1_de      = s1;
      rs1_used_de = u1;
      rs2_de      = s2;
      rs2_used_de = u2;
      BrTaken_ex  = br;
   endtask

   // Advance one clock edge and update the model with the inputs it sampled.
   task automatic tick();
      @(posedge clk);
      for (int l = 0; l < 4; l++) begin
         if (rst) cnt32[l] = 0;
         else if (exp_stall(l + 1)) cnt32[l] = cnt32[l] + 1;
      end
      if (rst) cnt_sat = 0;
      else if (exp_stall(2) && cnt_sat != 7) cnt_sat++;
      if (rst) loads.delete();
      else if (DMRd_ex && rd_ex != 0) loads.push_back('{cyc, rd_ex});
      cyc++;
      while (loads.size() > 0 && (cyc - loads[0].c) >= 4) void'(loads.pop_front());
      #1;
   endtask

   task automatic idle(int n);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Scenario tasks
   task automatic test_reset();
      drive(1, 1, 5'd4, 5'd4, 1, 5'd4, 1, 0);
      @(negedge clk);
      checks++;
      if (stall_v !== 4'b0000 || stall_c !== 1'b0) begin
         errors++;
         $display("FAIL reset_stall: got %b/%b required 0000/0", stall_v, stall_c);
      end
      tick();
      tick();
`ifdef HDU_STALL_CNT_EN
      @(negedge clk);
      checks++;
      if (cnt_c !== 3'd0 || cnt_l[0] !== 32'd0) begin
         errors++;
         $display("FAIL reset_cnt: got %0d/%0d required 0/0", cnt_c, cnt_l[0]);
      end
`endif
      idle(5);
   endtask

   task automatic test_lat1();
      drive(0, 1, 5'd4, 5'd0, 0, 5'd4, 1, 0);
      @(negedge clk);
      checks++;
      if (stall_v !== 4'b1111) begin
         errors++;
         $display("FAIL lat1_match: got %b required 1111", stall_v);
      end
      tick();
      drive(0, 1, 5'd8, 5'd0, 0, 5'd4, 1, 0);
      @(negedge clk);
      checks++;
      if (stall_v !== 4'b1110) begin
         errors++;
         $display("FAIL lat1_other_rd: got %b required 1110", stall_v);
      end
      tick();
      drive(0, 0, 5'd4, 5'd0, 0, 5'd4, 1, 0);
      @(negedge clk);
      checks++;
      if (stall_v !== 4'b1100) begin
         errors++;
         $display("FAIL lat1_no_load: got %b required 1100", stall_v);
      end
      idle(5);
   endtask

   task automatic test_latency_window();
      logic [3:0] exp_win [5];
      exp_win[0] = 4'b1111;
      exp_win[1] = 4'b1110;
      exp_win[2] = 4'b1100;
      exp_win[3] = 4'b1000;
      exp_win[4] = 4'b0000;
      drive(0, 1, 5'd5, 5'd5, 1, 5'd0, 0, 0);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if (stall_v !== exp_win[c]) begin
            errors++;
            $display("FAIL window_cycle%0d: got %b required %b", c, stall_v, exp_win[c]);
         end
         tick();
         drive(0, 0, 5'd5, 5'd5, 1, 5'd0, 0, 0);
      end
      idle(5);
   endtask

   task automatic test_exclusions();
      drive(0, 1, 5'd0, 5'd0, 1, 5'd0, 1, 0);
      @(negedge clk);
      checks++;
      if (stall_v !== 4'b0000) begin
         errors++;
         $display("FAIL excl_x0: got %b required 0000", stall_v);
      end
      tick();
      drive(0, 1, 5'd4, 5'd4, 0, 5'd9, 1, 0);
      @(negedge clk);
      checks++;
      if (stall_v !== 4'b0000) begin
         errors++;
         $display("FAIL excl_unused_ex: got %b required 0000", stall_v);
      end
      tick();
      drive(0, 0, 5'd0, 5'd4, 0, 5'd0, 1, 0);
      @(negedge clk);
      checks++;
      if (stall_v !== 4'b0000) begin
         errors++;
         $display("FAIL excl_unused_pend: got %b required 0000", stall_v);
      end
      idle(5);
   endtask

   task automatic test_priority();
      drive(0, 1, 5'd7, 5'd7, 1, 5'd0, 0, 1);
      @(negedge clk);
      checks++;
      if (stall_v !== 4'b0000) begin
         errors++;
         $display("FAIL br_priority: got %b required 0000", stall_v);
      end
      tick();
      drive(0, 0, 5'd0, 5'd7, 1, 5'd0, 0, 0);
      @(negedge clk);
      checks++;
      if (stall_v !== 4'b1110) begin
         errors++;
         $display("FAIL br_pend_shift: got %b required 1110", stall_v);
      end
      idle(5);
   endtask

   task automatic test_reset_mid();
      drive(0, 1, 5'd6, 5'd6, 1, 5'd0, 0, 0);
      @(negedge clk);
      checks++;
      if (stall_v !== 4'b1111) begin
         errors++;
         $display("FAIL rstmid_pre: got %b required 1111", stall_v);
      end
      tick();
      drive(1, 1, 5'd6, 5'd6, 1, 5'd0, 0, 0);
      @(negedge clk);
      checks++;
      if (stall_v !== 4'b0000) begin
         errors++;
         $display("FAIL rstmid_during: got %b required 0000", stall_v);
      end
      tick();
      drive(0, 0, 5'd0, 5'd6, 1, 5'd0, 0, 0);
      @(negedge clk);
      checks++;
      if (stall_v !== 4'b0000) begin
         errors++;
         $display("FAIL rstmid_after: got %b required 0000", stall_v);
      end
      idle(5);
   endtask

   task automatic test_counter();
`ifdef HDU_STALL_CNT_EN
      drive(1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0);
      tick();
      drive(0, 1, 5'd3, 5'd3, 1, 5'd3, 1, 0);
      for (int i = 0; i < 9; i++) begin
         tick();
         if (i == 2) begin
            @(negedge clk);
            checks++;
            if (cnt_c !== 3'd3 || stall_c !== 1'b1) begin
               errors++;
               $display("FAIL cnt_dual_3: got %0d stall %b required 3 stall 1", cnt_c, stall_c);
            end
         end
      end
      @(negedge clk);
      checks++;
      if (cnt_c !== 3'd7) begin
         errors++;
         $display("FAIL cnt_sat: got %0d required 7", cnt_c);
      end
      tick();
      @(negedge clk);
      checks++;
      if (cnt_c !== 3'd7) begin
         errors++;
         $display("FAIL cnt_hold: got %0d required 7", cnt_c);
      end
      drive(1, 1, 5'd3, 5'd3, 1, 5'd3, 1, 0);
      tick();
      drive(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0);
      @(negedge clk);
      checks++;
      if (cnt_c !== 3'd0) begin
         errors++;
         $display("FAIL cnt_reset: got %0d required 0", cnt_c);
      end
      idle(5);
`endif
   endtask

   task automatic test_random();
      logic [3:0] exp;
      for (int n = 0; n < 400; n++) begin
         drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 1) == 1),
               REG_W'($urandom_range(0, 7)), REG_W'($urandom_range(0, 7)),
               ($urandom_range(0, 3) != 0), REG_W'($urandom_range(0, 7)),
               ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0));
         @(negedge clk);
         exp_q.push_back({exp_stall(4), exp_stall(3), exp_stall(2), exp_stall(1)});
         exp = exp_q.pop_front();
         checks++;
         if (stall_v !== exp || stall_c !== exp[1]) begin
            errors++;
            $display("FAIL rand_stall n=%0d: got %b/%b required %b/%b", n, stall_v, stall_c, exp, exp[1]);
         end
`ifdef HDU_STALL_CNT_EN
         checks++;
         if (cnt_c !== CW'(cnt_sat) || cnt_l[0] !== cnt32[0] || cnt_l[1] !== cnt32[1] ||
             cnt_l[2] !== cnt32[2] || cnt_l[3] !== cnt32[3]) begin
            errors++;
            $display("FAIL rand_cnt n=%0d: got %0d %0d %0d %0d %0d required %0d %0d %0d %0d %0d", n,
                     cnt_c, cnt_l[0], cnt_l[1], cnt_l[2], cnt_l[3],
                     cnt_sat, cnt32[0], cnt32[1], cnt32[2], cnt32[3]);
         end
`endif
         tick();
      end
   endtask

   // Test sequence and final report
   initial begin
      for (int l = 0; l < 4; l++) cnt32[l] = 0;
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      test_reset();
      test_lat1();
      test_latency_window();
      test_exclusions();
      test_priority();
      test_reset_mid();
      test_counter();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
